// File: rtl/fifo_rr_drain_pkg.sv
// Shared definitions for the round-robin fifo drain scheduler.
//   state_e   : scheduler states (IDLE arbitrates, BURST issues reads)
//   BUF_DEPTH : number of entries in the output buffer
package fifo_rr_drain_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rr_drain_chk.sv
// Simulation checks for the drain scheduler's output buffer and read strobes.
//   clk, sclr : clock and synchronous reset of the checked block
//   occ       : output buffer occupancy
//   push, pop : buffer write / read strobes of the current cycle
//   rd_req    : per-queue read strobes
module fifo_rr_drain_chk #(
    parameter int NUM_Q = 4
) (
    input logic             clk,
    input logic             sclr,
    input logic [1:0]       occ,
    input logic             push,
    input logic             pop,
    input logic [NUM_Q-1:0] rd_req
);

    // A push into a full buffer without a simultaneous pop would lose a word.
    property p_no_overflow;
        @(posedge clk) disable iff (sclr) !((occ == 2'd2) && push && !pop);
    endproperty
    a_no_overflow: assert property (p_no_overflow);

    // At most one queue is read per cycle.
    property p_rd_onehot;
        @(posedge clk) disable iff (sclr) $onehot0(rd_req);
    endproperty
    a_rd_onehot: assert property (p_rd_onehot);

endmodule

// File: rtl/fifo_rr_drain_rr_pick.sv
// Combinational round-robin selector.
// Returns the first asserted request strictly after ptr, wrapping modulo
// NUM_Q (ptr itself is checked last).
//   req   : request vector, one bit per requester
//   ptr   : index of the most recently served requester
//   idx   : selected requester (0 when nothing is requested)
//   found : high when any request bit is set
module fifo_rr_drain_rr_pick #(
    parameter int NUM_Q = 4,
    parameter int QID_W = 2
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] ptr,
    output logic [QID_W-1:0] idx,
    output logic             found
);

    logic [QID_W-1:0] cand_s;
    logic             hit_s;

    // Walk the requesters in priority order starting just after ptr.
    always_comb begin
        idx    = '0;
        found  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 1; i <= NUM_Q; i++) begin
            cand_s = QID_W'((int'(ptr) + i) % NUM_Q);
            hit_s  = req[cand_s] & ~found;
            idx    = hit_s ? cand_s : idx;
            found  = found | hit_s;
        end
    end

endmodule

// File: rtl/fifo_rr_drain.sv
// Read-side scheduler draining NUM_Q showahead-off fifos (1-cycle read
// latency) round-robin, in bursts of up to MAX_BURST words, into a 2-entry
// valid/ready output buffer.
//   clk, sclr  : clock, synchronous active-high reset
//   enable     : permits new reads
//   q_empty    : per-queue empty flags
//   q_rd_req   : per-queue read strobes (one-hot or zero)
//   q_rd_dat   : per-queue read data, queue i at [i*DAT_WIDTH +: DAT_WIDTH]
//   out_dat    : head word of the output buffer, out_qid its source queue
//   out_valid  : buffer non-empty; out_ready pops the head word
//   busy       : bursting, read in flight, or buffer non-empty
//   cntr       : number of words popped (wraps)
module fifo_rr_drain
    import fifo_rr_drain_pkg::*;
#(
    parameter int NUM_Q     = 4,
    parameter int DAT_WIDTH = 16,
    parameter int QID_W     = 2,
    parameter int MAX_BURST = 4,
    parameter int BURST_W   = 3
) (
    input  logic                       clk,
    input  logic                       sclr,
    input  logic                       enable,
    input  logic [NUM_Q-1:0]           q_empty,
    output logic [NUM_Q-1:0]           q_rd_req,
    input  logic [NUM_Q*DAT_WIDTH-1:0] q_rd_dat,
    output logic [DAT_WIDTH-1:0]       out_dat,
    output logic [QID_W-1:0]           out_qid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [15:0]                cntr
);

    state_e               state_q, state_d;
    logic [QID_W-1:0]     grant_q, grant_d;
    logic [QID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 infl_q, infl_d;
    logic [QID_W-1:0]     infl_qid_q, infl_qid_d;
    logic [DAT_WIDTH-1:0] buf_dat_q [BUF_DEPTH];
    logic [DAT_WIDTH-1:0] buf_dat_d [BUF_DEPTH];
    logic [QID_W-1:0]     buf_qid_q [BUF_DEPTH];
    logic [QID_W-1:0]     buf_qid_d [BUF_DEPTH];
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic [15:0]          cntr_q, cntr_d;

    logic                 pop_s;
    logic                 push_s;
    logic                 room_s;
    logic                 issue_s;
    logic                 wr_idx_s;
    logic                 pick_found_s;
    logic [QID_W-1:0]     pick_idx_s;

    fifo_rr_drain_rr_pick #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_pick (
        .req   (~q_empty),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    fifo_rr_drain_chk #(
        .NUM_Q (NUM_Q)
    ) u_chk (
        .clk    (clk),
        .sclr   (sclr),
        .occ    (occ_q),
        .push   (push_s),
        .pop    (pop_s),
        .rd_req (q_rd_req)
    );

    // Issue decision: a read is only launched when the word it returns is
    // guaranteed a buffer slot, counting the word already in flight.
    always_comb begin
        pop_s    = (occ_q != 2'd0) & out_ready;
        push_s   = infl_q;
        wr_idx_s = rd_ptr_q ^ occ_q[0];
        room_s   = (({1'b0, occ_q} + {2'b00, infl_q}) - {2'b00, pop_s}) < 3'd2;
        issue_s  = (state_q == ST_BURST) & enable & ~q_empty[grant_q] & room_s;
        q_rd_req = issue_s ? (NUM_Q'(1'b1) << grant_q) : '0;
    end

    // Scheduler next state: arbitrate in IDLE, count issues in BURST.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && pick_found_s) begin
                    state_d = ST_BURST;
                    grant_d = pick_idx_s;
                    burst_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                burst_d = burst_q + BURST_W'(issue_s);
                if ((issue_s && (burst_d == BURST_W'(MAX_BURST))) || q_empty[grant_q] || !enable) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q;
                end else begin
                    state_d  = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read return path and output buffer bookkeeping.
    always_comb begin
        infl_d     = issue_s;
        infl_qid_d = grant_q;
        buf_dat_d  = buf_dat_q;
        buf_qid_d  = buf_qid_q;
        if (push_s) begin
            buf_dat_d[wr_idx_s] = q_rd_dat[infl_qid_q*DAT_WIDTH +: DAT_WIDTH];
            buf_qid_d[wr_idx_s] = infl_qid_q;
        end else begin
            buf_dat_d = buf_dat_q;
        end
        rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
        occ_d    = (occ_q + {1'b0, push_s}) - {1'b0, pop_s};
        cntr_d   = cntr_q + 16'(pop_s);
    end

    // State registers with synchronous reset; an in-flight word is dropped.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= QID_W'(NUM_Q - 1);
            burst_q    <= '0;
            infl_q     <= 1'b0;
            infl_qid_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_dat_q[i] <= '0;
                buf_qid_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            cntr_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            infl_q     <= infl_d;
            infl_qid_q <= infl_qid_d;
            buf_dat_q  <= buf_dat_d;
            buf_qid_q  <= buf_qid_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            cntr_q     <= cntr_d;
        end
    end

    // Outputs come straight from the buffer and status registers.
    always_comb begin
        out_valid = (occ_q != 2'd0);
        out_dat   = buf_dat_q[rd_ptr_q];
        out_qid   = buf_qid_q[rd_ptr_q];
        busy      = (state_q == ST_BURST) | infl_q | (occ_q != 2'd0);
        cntr      = cntr_q;
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
module tb_fifo_rr_drain;

    localparam int NUM_Q     = 4;
    localparam int DAT_WIDTH = 16;
    localparam int QID_W     = 2;
    localparam int MAX_BURST = 4;
    localparam int BURST_W   = 3;

    logic                       clk = 1'b0;
    logic                       sclr;
    logic                       enable;
    logic [NUM_Q-1:0]           q_empty;
    logic [NUM_Q-1:0]           q_rd_req;
    logic [NUM_Q*DAT_WIDTH-1:0] q_rd_dat;
    logic [DAT_WIDTH-1:0]       out_dat;
    logic [QID_W-1:0]           out_qid;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;
    logic [15:0]                cntr;

    always #5 clk = ~clk;

    fifo_rr_drain #(
        .NUM_Q     (NUM_Q),
        .DAT_WIDTH (DAT_WIDTH),
        .QID_W     (QID_W),
        .MAX_BURST (MAX_BURST),
        .BURST_W   (BURST_W)
    ) dut (
        .clk       (clk),
        .sclr      (sclr),
        .enable    (enable),
        .q_empty   (q_empty),
        .q_rd_req  (q_rd_req),
        .q_rd_dat  (q_rd_dat),
        .out_dat   (out_dat),
        .out_qid   (out_qid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .cntr      (cntr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // fifo contents as seen by the read port, and the words each queue is
    // still owed on the output, in order
    logic [DAT_WIDTH-1:0] fifo_q [NUM_Q][$];
    logic [DAT_WIDTH-1:0] exp_q  [NUM_Q][$];
    int                   issue_log [$];
    int                   pop_cnt;
    int                   held;
    logic [15:0]          cntr_m;
    bit                   rnd_load;

    logic [NUM_Q-1:0]     s_req;
    logic                 s_valid, s_pop, s_busy, s_sclr;
    logic [DAT_WIDTH-1:0] s_dat;
    logic [QID_W-1:0]     s_qid;
    logic [15:0]          s_cntr;
    logic                 prev_hold;
    logic [DAT_WIDTH-1:0] prev_dat;
    logic [QID_W-1:0]     prev_qid;

    typedef struct {
        logic             en;
        logic             rdy;
        logic [NUM_Q-1:0] rd_req;
        logic             valid;
        logic [15:0]      dat;
        logic             busy;
    } vec_t;

    vec_t tbl [16];
    int   grant_order [6] = '{0, 1, 3, 0, 1, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rd, input logic v, input logic [15:0] d, input logic b);
        vec_t r;
        r.en     = 1'b1;
        r.rdy    = 1'b1;
        r.rd_req = rd;
        r.valid  = v;
        r.dat    = d;
        r.busy   = b;
        return r;
    endfunction

    task automatic load(input int q, input int n, input logic [15:0] base);
        for (int k = 0; k < n; k++) begin
            fifo_q[q].push_back(base + 16'(k));
            exp_q[q].push_back(base + 16'(k));
        end
        q_empty[q] = 1'b0;
    endtask

    // One clock: sample and check at the falling edge, then advance the
    // fifo models just after the rising edge.
    task automatic cyc();
        int qi;
        int lq;
        @(negedge clk);
        s_req   = q_rd_req;
        s_valid = out_valid;
        s_pop   = out_valid & out_ready;
        s_busy  = busy;
        s_dat   = out_dat;
        s_qid   = out_qid;
        s_cntr  = cntr;
        s_sclr  = sclr;
        qi      = -1;
        chk("rd_req_onehot", 32'($onehot0(s_req)), 32'd1);
        chk("cntr_model", 32'(s_cntr), 32'(cntr_m));
        if (prev_hold) begin
            chk("hold_valid", 32'(s_valid), 32'd1);
            chk("hold_dat", 32'(s_dat), 32'(prev_dat));
            chk("hold_qid", 32'(s_qid), 32'(prev_qid));
        end
        for (int i = 0; i < NUM_Q; i++) begin
            if (s_req[i]) qi = i;
        end
        if (qi >= 0) begin
            issue_log.push_back(qi);
            chk("rd_needs_enable", 32'(enable), 32'd1);
            chk("rd_not_empty", 32'(fifo_q[qi].size() > 0), 32'd1);
            chk("rd_room", 32'((held - int'(s_pop)) < 2), 32'd1);
            held++;
        end
        if (s_pop) begin
            pop_cnt++;
            cntr_m++;
            held--;
            chk("pop_owed", 32'(exp_q[s_qid].size() > 0), 32'd1);
            if (exp_q[s_qid].size() > 0) chk("pop_dat", 32'(s_dat), 32'(exp_q[s_qid].pop_front()));
        end
        prev_hold = s_valid & ~out_ready & ~s_sclr;
        prev_dat  = s_dat;
        prev_qid  = s_qid;
        @(posedge clk);
        #1;
        if (s_sclr) begin
            for (int i = 0; i < NUM_Q; i++) begin
                fifo_q[i].delete();
                exp_q[i].delete();
            end
            held      = 0;
            cntr_m    = 16'd0;
            prev_hold = 1'b0;
        end else if (qi >= 0 && fifo_q[qi].size() > 0) begin
            q_rd_dat[qi*DAT_WIDTH +: DAT_WIDTH] = fifo_q[qi].pop_front();
        end
        if (rnd_load && $urandom_range(0, 2) == 0) begin
            lq = int'($urandom_range(0, NUM_Q - 1));
            if (fifo_q[lq].size() < 12) begin
                fifo_q[lq].push_back(16'($urandom));
                exp_q[lq].push_back(fifo_q[lq][fifo_q[lq].size() - 1]);
            end
        end
        for (int i = 0; i < NUM_Q; i++) q_empty[i] = (fifo_q[i].size() == 0);
    endtask

    initial begin
        bit done;
        int owed;

        // queue 2 holds words 0x2200.. ; bursts of 4, 4, 2 with one idle cycle between
        tbl[0]  = mk(4'b0000, 1'b0, 16'h0000, 1'b0);
        tbl[1]  = mk(4'b0100, 1'b0, 16'h0000, 1'b1);
        tbl[2]  = mk(4'b0100, 1'b0, 16'h0000, 1'b1);
        tbl[3]  = mk(4'b0100, 1'b1, 16'h2200, 1'b1);
        tbl[4]  = mk(4'b0100, 1'b1, 16'h2201, 1'b1);
        tbl[5]  = mk(4'b0000, 1'b1, 16'h2202, 1'b1);
        tbl[6]  = mk(4'b0100, 1'b1, 16'h2203, 1'b1);
        tbl[7]  = mk(4'b0100, 1'b0, 16'h0000, 1'b1);
        tbl[8]  = mk(4'b0100, 1'b1, 16'h2204, 1'b1);
        tbl[9]  = mk(4'b0100, 1'b1, 16'h2205, 1'b1);
        tbl[10] = mk(4'b0000, 1'b1, 16'h2206, 1'b1);
        tbl[11] = mk(4'b0100, 1'b1, 16'h2207, 1'b1);
        tbl[12] = mk(4'b0100, 1'b0, 16'h0000, 1'b1);
        tbl[13] = mk(4'b0000, 1'b1, 16'h2208, 1'b1);
        tbl[14] = mk(4'b0000, 1'b1, 16'h2209, 1'b1);
        tbl[15] = mk(4'b0000, 1'b0, 16'h0000, 1'b0);

        sclr      = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        q_empty   = '1;
        q_rd_dat  = '0;
        rnd_load  = 1'b0;
        held      = 0;
        pop_cnt   = 0;
        cntr_m    = 16'd0;
        prev_hold = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_dat", 32'(out_dat), 32'd0);
        chk("rst_out_qid", 32'(out_qid), 32'd0);
        chk("rst_rd_req", 32'(q_rd_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cntr", 32'(cntr), 32'd0);
        @(posedge clk);
        #1;
        sclr = 1'b0;

        // all queues empty
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("empty_rd_req", 32'(s_req), 32'd0);
            chk("empty_valid", 32'(s_valid), 32'd0);
            chk("empty_busy", 32'(s_busy), 32'd0);
        end

        // three queues round-robin, 4 words per grant
        load(0, 8, 16'h0A00);
        load(1, 8, 16'h1A00);
        load(3, 8, 16'h3A00);
        issue_log.delete();
        pop_cnt = 0;
        repeat (80) cyc();
        chk("rr_issue_count", 32'(issue_log.size()), 32'd24);
        for (int k = 0; k < 24 && k < issue_log.size(); k++) chk("rr_grant_order", 32'(issue_log[k]), 32'(grant_order[k / 4]));
        chk("rr_pop_count", 32'(pop_cnt), 32'd24);
        chk("rr_idle", 32'(s_busy), 32'd0);

        // cycle-exact burst pattern on a single queue
        load(2, 10, 16'h2200);
        pop_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            enable    = tbl[c].en;
            out_ready = tbl[c].rdy;
            cyc();
            chk($sformatf("tbl_rd_req[%0d]", c), 32'(s_req), 32'(tbl[c].rd_req));
            chk($sformatf("tbl_valid[%0d]", c), 32'(s_valid), 32'(tbl[c].valid));
            chk($sformatf("tbl_busy[%0d]", c), 32'(s_busy), 32'(tbl[c].busy));
            if (tbl[c].valid) begin
                chk($sformatf("tbl_dat[%0d]", c), 32'(s_dat), 32'(tbl[c].dat));
                chk($sformatf("tbl_qid[%0d]", c), 32'(s_qid), 32'd2);
            end
        end
        chk("single_q_pops", 32'(pop_cnt), 32'd10);
        chk("single_q_cntr", 32'(s_cntr), 32'd34);

        // backpressure: two reads then hold
        load(0, 6, 16'h0B00);
        issue_log.delete();
        pop_cnt   = 0;
        out_ready = 1'b0;
        repeat (20) cyc();
        chk("bp_issue_count", 32'(issue_log.size()), 32'd2);
        chk("bp_valid", 32'(s_valid), 32'd1);
        chk("bp_head_dat", 32'(s_dat), 32'h0B00);
        chk("bp_head_qid", 32'(s_qid), 32'd0);
        out_ready = 1'b1;
        repeat (30) cyc();
        chk("bp_pop_count", 32'(pop_cnt), 32'd6);
        chk("bp_issue_total", 32'(issue_log.size()), 32'd6);
        chk("bp_idle", 32'(s_busy), 32'd0);

        // enable drops after the second issue
        load(1, 8, 16'h1B00);
        issue_log.delete();
        pop_cnt = 0;
        for (int k = 0; k < 10 && issue_log.size() < 2; k++) cyc();
        enable = 1'b0;
        repeat (6) cyc();
        chk("en_issue_count", 32'(issue_log.size()), 32'd2);
        chk("en_pop_count", 32'(pop_cnt), 32'd2);
        chk("en_idle", 32'(s_busy), 32'd0);
        enable = 1'b1;
        issue_log.delete();
        cyc();
        chk("en_arb_cycle", 32'(s_req), 32'd0);
        cyc();
        chk("en_restart_q1", 32'(s_req), 32'h2);
        repeat (30) cyc();
        chk("en_pop_total", 32'(pop_cnt), 32'd8);

        // synchronous reset with a word in flight
        load(3, 4, 16'h3C00);
        issue_log.delete();
        for (int k = 0; k < 10 && issue_log.size() < 1; k++) cyc();
        sclr = 1'b1;
        cyc();
        sclr = 1'b0;
        pop_cnt = 0;
        cyc();
        chk("sclr_valid", 32'(s_valid), 32'd0);
        chk("sclr_cntr", 32'(s_cntr), 32'd0);
        chk("sclr_rd_req", 32'(s_req), 32'd0);
        repeat (5) cyc();
        chk("sclr_no_stale_word", 32'(pop_cnt), 32'd0);

        // randomized traffic against the scoreboard
        rnd_load = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        rnd_load  = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        done      = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            cyc();
            done = (q_empty == '1) && !s_busy;
        end
        chk("rnd_drained", 32'(done), 32'd1);
        owed = 0;
        for (int i = 0; i < NUM_Q; i++) owed += exp_q[i].size();
        chk("rnd_words_owed", 32'(owed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
